// File: rtl/l1_mau_arb.sv
// l1_mau_arb: shares the single memory access unit port between L1I and L1D.
// Round-robin grant from IDLE, one outstanding downstream request at a time,
// combinational ack/data return to the owner, sticky timeout flag.
module l1_mau_arb #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req_val,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    output logic                      i_req_ack,
    output logic [LINE_WIDTH-1:0]     i_ack_data,
    input  logic                      d_req_val,
    input  logic [ADDR_WIDTH-1:0]     d_req_addr,
    input  logic                      d_req_cop,
    input  logic [LINE_WIDTH-1:0]     d_req_wdata,
    input  logic [LINE_WIDTH/8-1:0]   d_req_be,
    output logic                      d_req_ack,
    output logic [LINE_WIDTH-1:0]     d_ack_data,
    output logic                      mem_req_val,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic                      mem_req_cop,
    output logic [LINE_WIDTH-1:0]     mem_req_wdata,
    output logic [LINE_WIDTH/8-1:0]   mem_req_be,
    input  logic                      mem_req_ack,
    input  logic [LINE_WIDTH-1:0]     mem_ack_data,
    output logic                      err
);

    localparam int BE_WIDTH = LINE_WIDTH / 8;
    // Keep the counter at least one bit wide so a disabled timeout still elaborates.
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t                  state_reg;
    logic                    prio_d_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    err_reg;
    logic                    orphan_reg;
    logic                    mem_req_val_reg;
    logic                    mem_req_cop_reg;
    logic [ADDR_WIDTH-1:0]   mem_req_addr_reg;
    logic [LINE_WIDTH-1:0]   mem_req_wdata_reg;
    logic [BE_WIDTH-1:0]     mem_req_be_reg;

    logic                    grant_d;
    logic                    grant_i;
    logic [1:0]              busy_vec;
    logic [1:0]              ack_vec;
    logic [LINE_WIDTH-1:0]   ack_data_arr [2];

    // L1D wins when it is alone or holds priority; L1I otherwise.
    assign grant_d = d_req_val && (!i_req_val || prio_d_reg);
    assign grant_i = i_req_val && !grant_d;

    // Index 0 is L1I, index 1 is L1D.
    assign busy_vec = {state_reg == BUSY_D, state_reg == BUSY_I};

    // Ack and data are a same-cycle pass-through of the memory response to the owner only;
    // gated by rst so a response arriving during reset never reaches a cache.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi]      = busy_vec[gi] & mem_req_ack & ~rst;
            assign ack_data_arr[gi] = ack_vec[gi] ? mem_ack_data : '0;
        end
    endgenerate

    assign i_req_ack     = ack_vec[0];
    assign d_req_ack     = ack_vec[1];
    assign i_ack_data    = ack_data_arr[0];
    assign d_ack_data    = ack_data_arr[1];
    assign mem_req_val   = mem_req_val_reg;
    assign mem_req_addr  = mem_req_addr_reg;
    assign mem_req_cop   = mem_req_cop_reg;
    assign mem_req_wdata = mem_req_wdata_reg;
    assign mem_req_be    = mem_req_be_reg;
    assign err           = err_reg;

    // Arbitration FSM with registered downstream request, priority and timeout tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            prio_d_reg        <= 1'b1;
            cnt_reg           <= '0;
            err_reg           <= 1'b0;
            mem_req_val_reg   <= 1'b0;
            mem_req_cop_reg   <= 1'b0;
            mem_req_addr_reg  <= '0;
            mem_req_wdata_reg <= '0;
            mem_req_be_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        state_reg         <= BUSY_D;
                        mem_req_val_reg   <= 1'b1;
                        mem_req_addr_reg  <= d_req_addr;
                        mem_req_cop_reg   <= d_req_cop;
                        mem_req_wdata_reg <= d_req_cop ? d_req_wdata : '0;
                        mem_req_be_reg    <= d_req_cop ? d_req_be : '0;
                        cnt_reg           <= '0;
                    end else if (grant_i) begin
                        state_reg         <= BUSY_I;
                        mem_req_val_reg   <= 1'b1;
                        mem_req_addr_reg  <= i_req_addr;
                        mem_req_cop_reg   <= 1'b0;
                        mem_req_wdata_reg <= '0;
                        mem_req_be_reg    <= '0;
                        cnt_reg           <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_req_ack) begin
                        // Completion forces one IDLE cycle and hands priority to the other side.
                        state_reg       <= IDLE;
                        mem_req_val_reg <= 1'b0;
                        prio_d_reg      <= (state_reg == BUSY_I);
                    end else if (TIMEOUT_EN) begin
                        if (cnt_reg != CNT_MAX) begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                        if (cnt_reg == CNT_LAST) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    mem_req_val_reg <= 1'b0;
                end
            endcase
        end
    end

    // Remembers a downstream request abandoned by reset, whose late ack is legitimately expected.
    always_ff @(posedge clk) begin
        if (rst) begin
            orphan_reg <= (state_reg != IDLE);
        end else if (state_reg == IDLE && (mem_req_ack || grant_d || grant_i)) begin
            orphan_reg <= 1'b0;
        end
    end

    // Flags an unsolicited memory ack while idle (late acks of reset-abandoned requests excepted).
    always_ff @(posedge clk) begin
        if (!rst && state_reg == IDLE && !orphan_reg) begin
            assert (!mem_req_ack)
            else $error("l1_mau_arb: mem_req_ack received while idle");
        end
    end

endmodule
